// File: rtl/rng_stream_buffer_if.sv
// Bundled control/status signals of rng_stream_buffer: the master drives
// mode/trigger/burst_len/stop/pop, the slave returns read data and FIFO status.
interface rng_stream_if #(
  parameter int DATA_WIDTH      = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int BURST_LEN_WIDTH = 4
);
  localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]                 mode;
  logic                       trigger;
  logic [BURST_LEN_WIDTH-1:0] burst_len;
  logic                       stop;
  logic                       pop;
  logic [DATA_WIDTH-1:0]      data_out;
  logic                       data_out_valid;
  logic                       empty;
  logic                       full;
  logic [LEVEL_WIDTH-1:0]     level;
  logic                       busy;

  modport master (
    output mode, trigger, burst_len, stop, pop,
    input  data_out, data_out_valid, empty, full, level, busy
  );

  modport slave (
    input  mode, trigger, burst_len, stop, pop,
    output data_out, data_out_valid, empty, full, level, busy
  );
endinterface

// File: rtl/rng_stream_buffer.sv
// Multi-bit-per-clock Galois LFSR feeding a synchronous FIFO, sequenced by a
// SINGLE/BURST/CONT mode FSM. Define RNG_STREAM_BURST_EN to enable BURST counting.
module rng_stream_buffer #(
  parameter int                    LFSR_WIDTH      = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED       = 8'h01,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY       = 8'hB8,
  parameter int                    DATA_WIDTH      = 4,
  parameter int                    FIFO_DEPTH      = 16,
  parameter int                    BURST_LEN_WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  rng_stream_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CONT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic [LFSR_WIDTH-1:0] w_lfsr_nxt;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [LW-1:0]         w_level_nxt;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_out_valid;
  logic                  w_push;
  logic                  w_pop;

`ifdef RNG_STREAM_BURST_EN
  localparam int CW = BURST_LEN_WIDTH + 1;
  localparam logic [CW-1:0] BURST_MAX = {1'b1, {BURST_LEN_WIDTH{1'b0}}};
  logic [CW-1:0] r_remaining;
  logic [CW-1:0] w_remaining_nxt;
`else
  logic w_unused_burst_len;
  assign w_unused_burst_len = ^bus.burst_len;
`endif

  // DATA_WIDTH Galois steps; the first step's output bit lands in word bit 0
  function automatic logic [LFSR_WIDTH+DATA_WIDTH-1:0] lfsr_word(
    input logic [LFSR_WIDTH-1:0] s_in
  );
    logic [LFSR_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] w;
    logic                  b;
    s = s_in;
    w = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      b    = s[0];
      w[i] = b;
      s    = (s >> 1) ^ (b ? LFSR_POLY : {LFSR_WIDTH{1'b0}});
    end
    return {s, w};
  endfunction

  // Next LFSR state and the word it produces
  always_comb begin
    {w_lfsr_nxt, w_word} = lfsr_word(r_lfsr);
  end

  assign w_push = (r_state != S_IDLE) && !r_full && !bus.stop;
  assign w_pop  = bus.pop && !r_empty;

  // Occupancy counter update
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Mode FSM next-state logic; stop always wins over trigger and pushes
  always_comb begin
    w_state_nxt = r_state;
`ifdef RNG_STREAM_BURST_EN
    w_remaining_nxt = r_remaining;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.trigger && !bus.stop) begin
          case (bus.mode)
`ifdef RNG_STREAM_BURST_EN
            2'b00: begin
              w_state_nxt     = S_RUN;
              w_remaining_nxt = CW'(1);
            end
            2'b01: begin
              w_state_nxt     = S_RUN;
              w_remaining_nxt = (bus.burst_len == {BURST_LEN_WIDTH{1'b0}}) ?
                                BURST_MAX : {1'b0, bus.burst_len};
            end
`else
            2'b00, 2'b01: w_state_nxt = S_RUN;
`endif
            2'b10:   w_state_nxt = S_CONT;
            default: w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_push) begin
`ifdef RNG_STREAM_BURST_EN
          if (r_remaining == CW'(1)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt     = S_RUN;
            w_remaining_nxt = r_remaining - CW'(1);
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_CONT: begin
        if (bus.stop || (bus.mode != 2'b10)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_CONT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM, LFSR, pointers, status and read-data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_lfsr           <= LFSR_SEED;
      r_wr_ptr         <= {PW{1'b0}};
      r_rd_ptr         <= {PW{1'b0}};
      r_level          <= {LW{1'b0}};
      r_empty          <= 1'b1;
      r_full           <= 1'b0;
      r_busy           <= 1'b0;
      r_data_out       <= {DATA_WIDTH{1'b0}};
      r_data_out_valid <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_level          <= w_level_nxt;
      r_empty          <= (w_level_nxt == {LW{1'b0}});
      r_full           <= (w_level_nxt == FULL_LEVEL);
      r_busy           <= (w_state_nxt != S_IDLE);
      r_data_out_valid <= w_pop;
      if (w_push) begin
        r_lfsr   <= w_lfsr_nxt;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end else begin
        r_lfsr   <= r_lfsr;
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + PW'(1);
      end else begin
        r_data_out <= r_data_out;
        r_rd_ptr   <= r_rd_ptr;
      end
    end
  end

`ifdef RNG_STREAM_BURST_EN
  // Burst down-counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_remaining <= {CW{1'b0}};
    end else begin
      r_remaining <= w_remaining_nxt;
    end
  end
`endif

  // Storage array, intentionally without reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  assign bus.data_out       = r_data_out;
  assign bus.data_out_valid = r_data_out_valid;
  assign bus.empty          = r_empty;
  assign bus.full           = r_full;
  assign bus.level          = r_level;
  assign bus.busy           = r_busy;
endmodule
